// File: rtl/fifo_wr_packer.sv
// fifo_wr_packer
//
// Write-domain producer that sits in front of the async FIFO write-pointer
// block. It accepts 8- or 16-bit words from a valid/ready source and
// serializes them into byte writes, low byte first. It keeps its own copy of
// the FIFO binary write pointer (wcount) and compares it against the
// synchronized Gray read pointer. As a result, winc only asserts when the
// FIFO is certain to take the byte. A stale wfull or a lagging read pointer
// can only delay a write. It never drops or duplicates a byte.
//
// Ports:
//   wclk         write-domain clock
//   wrst_n       asynchronous active-low reset, shared with the FIFO block
//   in_data      result word (2*DATA_W); the low byte is sent first
//   in_two       1 = send both bytes, 0 = send the low byte only
//   in_valid     source presents a word
//   in_ready     packer can accept a word (IDLE only)
//   wq2_rptr     Gray read pointer, already synchronized into wclk
//   wfull        registered full flag from the FIFO write-pointer block
//   winc         write strobe to the FIFO
//   wdata        byte to write, valid while winc=1
//   fill_level   conservative occupancy, 0..2^ADDR_W
//   almost_full  fill_level >= AF_LEVEL (advisory, does not gate writes)

module fifo_wr_packer #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int AF_LEVEL = 12
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic [2*DATA_W-1:0] in_data,
    input  logic                in_two,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W:0]     wq2_rptr,
    input  logic                wfull,
    output logic                winc,
    output logic [DATA_W-1:0]   wdata,
    output logic [ADDR_W:0]     fill_level,
    output logic                almost_full
);

    localparam logic [ADDR_W:0] DEPTH  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AF_THR = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE    = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W:0]       wcount_q, wcount_d;
    logic [2*DATA_W-1:0]   hold_q, hold_d;
    logic                  two_q, two_d;

    logic [ADDR_W:0]       rbin;
    logic                  space_ok;

    // Gray-to-binary conversion of the synchronized read pointer. Each binary
    // bit is the XOR of all Gray bits at or above it, so we walk down from
    // the MSB.
    always_comb begin
        rbin         = '0;
        rbin[ADDR_W] = wq2_rptr[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ wq2_rptr[i];
        end
    end

    // Both pointers carry one extra wrap bit. Their modular difference is
    // therefore the true occupancy, even across the wcount 2^(ADDR_W+1)
    // wrap. The read pointer can only lag, so the occupancy is an
    // over-estimate and is always safe to write against. wfull is also
    // honoured because the FIFO block may know something we do not.
    always_comb begin
        fill_level  = wcount_q - rbin;
        space_ok    = (fill_level < DEPTH) && !wfull;
        almost_full = (fill_level >= AF_THR);
    end

    // Next-state and output logic. A byte is only counted when winc is
    // actually driven. A stall simply leaves the state and hold register
    // untouched, so wdata stays stable until space appears.
    always_comb begin
        state_d  = state_q;
        wcount_d = wcount_q;
        hold_d   = hold_q;
        two_d    = two_q;
        in_ready = 1'b0;
        winc     = 1'b0;
        wdata    = hold_q[DATA_W-1:0];

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    hold_d  = in_data;
                    two_d   = in_two;
                    state_d = SEND_LO;
                end
            end
            SEND_LO: begin
                wdata = hold_q[DATA_W-1:0];
                winc  = space_ok;
                if (space_ok) begin
                    wcount_d = wcount_q + ONE;
                    state_d  = two_q ? SEND_HI : IDLE;
                end
            end
            SEND_HI: begin
                wdata = hold_q[2*DATA_W-1:DATA_W];
                winc  = space_ok;
                if (space_ok) begin
                    wcount_d = wcount_q + ONE;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. The reset discards any partially sent word. It also
    // realigns wcount with the FIFO write pointer, which shares this reset.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q  <= IDLE;
            wcount_q <= '0;
            hold_q   <= '0;
            two_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcount_q <= wcount_d;
            hold_q   <= hold_d;
            two_q    <= two_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// tb_fifo_wr_packer
//
// Directed bench for fifo_wr_packer. Each scenario task drives its own
// stimulus and compares the DUT outputs against hand-computed values. A
// running byte count and the reader position (ref_count and rbin_tb)
// provide the expected fill level.

module tb_fifo_wr_packer;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    logic                wclk;
    logic                wrst_n;
    logic [2*DATA_W-1:0] in_data;
    logic                in_two;
    logic                in_valid;
    logic                in_ready;
    logic [ADDR_W:0]     wq2_rptr;
    logic                wfull;
    logic                winc;
    logic [DATA_W-1:0]   wdata;
    logic [ADDR_W:0]     fill_level;
    logic                almost_full;

    int total;
    int bad;
    int ref_count;
    int rbin_tb;

    fifo_wr_packer #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .AF_LEVEL(12)
    ) dut (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .in_data    (in_data),
        .in_two     (in_two),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wq2_rptr   (wq2_rptr),
        .wfull      (wfull),
        .winc       (winc),
        .wdata      (wdata),
        .fill_level (fill_level),
        .almost_full(almost_full)
    );

    // Free-running write clock, 10 time-unit period.
    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // Safety net in case a scenario stalls indefinitely.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "[TB] watchdog");
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    // Place the reader at binary position b and present it in Gray form.
    task automatic set_rptr(input int b);
        logic [ADDR_W:0] bb;
        rbin_tb  = b % 32;
        bb       = (ADDR_W+1)'(rbin_tb);
        wq2_rptr = bb ^ (bb >> 1);
    endtask

    function automatic logic [ADDR_W:0] exp_fill();
        return (ADDR_W+1)'((ref_count - rbin_tb + 64) % 32);
    endfunction

    task automatic do_reset();
        wrst_n   = 1'b0;
        in_valid = 1'b0;
        in_two   = 1'b0;
        in_data  = '0;
        wfull    = 1'b0;
        set_rptr(0);
        ref_count = 0;
        step();
        step();
        wrst_n = 1'b1;
        step();
    endtask

    // Pure stimulus: hand a word over and wait (bounded) for each byte.
    // ok drops if a handshake or byte never appears or a byte is wrong.
    task automatic push_word(input logic [15:0] d, input logic two, output logic ok);
        int          n;
        logic        got;
        logic [7:0]  expb;
        ok       = 1'b1;
        in_data  = d;
        in_two   = two;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) ok = 1'b0;
        step();
        in_valid = 1'b0;
        for (int b = 0; b < (two ? 2 : 1); b++) begin
            expb = (b == 0) ? d[7:0] : d[15:8];
            got  = 1'b0;
            for (int k = 0; k < 50; k++) begin
                #1;
                if (winc) begin
                    if (wdata !== expb) ok = 1'b0;
                    got = 1'b1;
                    step();
                    ref_count = (ref_count + 1) % 32;
                    break;
                end
                step();
            end
            if (!got) ok = 1'b0;
        end
    endtask

    // Reset held with a valid word waiting: nothing may be accepted or written.
    task automatic test_reset();
        wrst_n   = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        in_two   = 1'b1;
        wfull    = 1'b0;
        set_rptr(0);
        ref_count = 0;
        step();
        step();
        total++; if (winc !== 1'b0) begin bad++; $display("[TB] FAIL reset_winc got=%b exp=0", winc); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (fill_level !== 5'd0) begin bad++; $display("[TB] FAIL reset_fill got=%0d exp=0", fill_level); end
        total++; if (almost_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_af got=%b exp=0", almost_full); end
        total++; if (wdata !== 8'h00) begin bad++; $display("[TB] FAIL reset_wdata got=%h exp=00", wdata); end
        in_valid = 1'b0;
        wrst_n   = 1'b1;
        step();
        #1;
        total++; if (in_ready !== 1'b1 || winc !== 1'b0) begin bad++; $display("[TB] FAIL reset_release got=rdy%b/winc%b exp=rdy1/winc0", in_ready, winc); end
    endtask

    // One low byte, with exact cycle latency.
    task automatic test_single();
        in_data  = 16'h12A5;
        in_two   = 1'b0;
        in_valid = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL single_ready0 got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        #1;
        total++; if (winc !== 1'b1) begin bad++; $display("[TB] FAIL single_winc got=%b exp=1", winc); end
        total++; if (wdata !== 8'hA5) begin bad++; $display("[TB] FAIL single_wdata got=%h exp=a5", wdata); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL single_busy got=%b exp=0", in_ready); end
        step();
        ref_count = 1;
        #1;
        total++; if (winc !== 1'b0) begin bad++; $display("[TB] FAIL single_winc_done got=%b exp=0", winc); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL single_ready1 got=%b exp=1", in_ready); end
        total++; if (fill_level !== 5'd1) begin bad++; $display("[TB] FAIL single_fill got=%0d exp=1", fill_level); end
    endtask

    // Two-byte word, low byte first, then fill up to the almost_full threshold.
    task automatic test_two_bytes();
        logic ok;
        in_data  = 16'hBEEF;
        in_two   = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        total++; if (winc !== 1'b1 || wdata !== 8'hEF) begin bad++; $display("[TB] FAIL two_lo got=%b/%h exp=1/ef", winc, wdata); end
        step();
        #1;
        total++; if (winc !== 1'b1 || wdata !== 8'hBE) begin bad++; $display("[TB] FAIL two_hi got=%b/%h exp=1/be", winc, wdata); end
        total++; if (fill_level !== 5'd2) begin bad++; $display("[TB] FAIL two_fill_mid got=%0d exp=2", fill_level); end
        step();
        ref_count = 3;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL two_ready got=%b exp=1", in_ready); end
        total++; if (fill_level !== 5'd3) begin bad++; $display("[TB] FAIL two_fill got=%0d exp=3", fill_level); end
        while (ref_count < 11) begin
            push_word({8'h00, 8'(ref_count)}, 1'b0, ok);
            total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL af_push got=%b exp=1", ok); end
        end
        #1;
        total++; if (fill_level !== 5'd11 || almost_full !== 1'b0) begin bad++; $display("[TB] FAIL af_below got=%0d/%b exp=11/0", fill_level, almost_full); end
        push_word(16'h0033, 1'b0, ok);
        #1;
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL af_push12 got=%b exp=1", ok); end
        total++; if (fill_level !== 5'd12 || almost_full !== 1'b1) begin bad++; $display("[TB] FAIL af_at got=%0d/%b exp=12/1", fill_level, almost_full); end
    endtask

    // FIFO full with the reader parked: the 17th byte stalls until the reader moves.
    task automatic test_full_stall();
        logic ok;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            push_word({8'h00, 8'(i + 8'h40)}, 1'b0, ok);
            total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL full_push%0d got=%b exp=1", i, ok); end
        end
        #1;
        total++; if (fill_level !== 5'd16 || almost_full !== 1'b1) begin bad++; $display("[TB] FAIL full_level got=%0d/%b exp=16/1", fill_level, almost_full); end
        in_data  = 16'h0077;
        in_two   = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        total++; if (winc !== 1'b0 || wdata !== 8'h77 || in_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_stall1 got=%b/%h/%b exp=0/77/0", winc, wdata, in_ready); end
        step();
        #1;
        total++; if (winc !== 1'b0 || wdata !== 8'h77) begin bad++; $display("[TB] FAIL full_stall2 got=%b/%h exp=0/77", winc, wdata); end
        set_rptr(1);
        #1;
        total++; if (winc !== 1'b1 || wdata !== 8'h77) begin bad++; $display("[TB] FAIL full_release got=%b/%h exp=1/77", winc, wdata); end
        total++; if (fill_level !== 5'd15) begin bad++; $display("[TB] FAIL full_release_fill got=%0d exp=15", fill_level); end
        step();
        ref_count = 17;
        #1;
        total++; if (fill_level !== 5'd16 || in_ready !== 1'b1 || winc !== 1'b0) begin bad++; $display("[TB] FAIL full_after got=%0d/%b/%b exp=16/1/0", fill_level, in_ready, winc); end
    endtask

    // A stale wfull delays the write by the exact stall length, with no loss or duplicate.
    task automatic test_stale_wfull();
        logic ok;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_word({8'h00, 8'(i)}, 1'b0, ok);
            total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL stale_push%0d got=%b exp=1", i, ok); end
        end
        #1;
        total++; if (fill_level !== 5'd3) begin bad++; $display("[TB] FAIL stale_fill3 got=%0d exp=3", fill_level); end
        wfull    = 1'b1;
        in_data  = 16'h005A;
        in_two   = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        total++; if (winc !== 1'b0) begin bad++; $display("[TB] FAIL stale_block1 got=%b exp=0", winc); end
        step();
        #1;
        total++; if (winc !== 1'b0 || wdata !== 8'h5A) begin bad++; $display("[TB] FAIL stale_block2 got=%b/%h exp=0/5a", winc, wdata); end
        wfull = 1'b0;
        #1;
        total++; if (winc !== 1'b1 || wdata !== 8'h5A) begin bad++; $display("[TB] FAIL stale_write got=%b/%h exp=1/5a", winc, wdata); end
        step();
        ref_count = 4;
        #1;
        total++; if (fill_level !== 5'd4 || winc !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL stale_after got=%0d/%b/%b exp=4/0/1", fill_level, winc, in_ready); end
    endtask

    // 40 bytes through the wcount wrap with a trailing reader, then reset inside SEND_HI.
    task automatic test_wrap_reset();
        logic ok;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            push_word({8'(2*i + 1), 8'(2*i)}, 1'b1, ok);
            total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL wrap_push%0d got=%b exp=1", i, ok); end
            #1;
            total++; if (fill_level !== exp_fill()) begin bad++; $display("[TB] FAIL wrap_fill_pre%0d got=%0d exp=%0d", i, fill_level, exp_fill()); end
            set_rptr((ref_count - (i % 4) + 32) % 32);
            #1;
            total++; if (fill_level !== 5'(i % 4)) begin bad++; $display("[TB] FAIL wrap_fill%0d got=%0d exp=%0d", i, fill_level, i % 4); end
        end
        in_data  = 16'hC3D4;
        in_two   = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        total++; if (winc !== 1'b1 || wdata !== 8'hD4) begin bad++; $display("[TB] FAIL wrap_lo got=%b/%h exp=1/d4", winc, wdata); end
        step();
        #1;
        total++; if (winc !== 1'b1 || wdata !== 8'hC3) begin bad++; $display("[TB] FAIL wrap_hi got=%b/%h exp=1/c3", winc, wdata); end
        wrst_n = 1'b0;
        set_rptr(0);
        ref_count = 0;
        #1;
        total++; if (winc !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL midreset got=%b/%b exp=0/1", winc, in_ready); end
        total++; if (fill_level !== 5'd0 || wdata !== 8'h00) begin bad++; $display("[TB] FAIL midreset_fill got=%0d/%h exp=0/00", fill_level, wdata); end
        step();
        wrst_n = 1'b1;
        step();
        #1;
        total++; if (winc !== 1'b0 || in_ready !== 1'b1 || fill_level !== 5'd0) begin bad++; $display("[TB] FAIL midreset_after got=%b/%b/%0d exp=0/1/0", winc, in_ready, fill_level); end
    endtask

    // Scenario sequence.
    initial begin
        total    = 0;
        bad      = 0;
        wrst_n   = 1'b0;
        in_valid = 1'b0;
        in_two   = 1'b0;
        in_data  = '0;
        wfull    = 1'b0;
        set_rptr(0);
        ref_count = 0;
        test_reset();
        test_single();
        test_two_bytes();
        test_full_stall();
        test_stale_wfull();
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
